// File: rtl/posit_encoder_pipe.sv
// Posit encoder: {sign, regime k, exponent, fraction, zero, NaR} -> WIDTH-bit posit, RNE, saturating; 3-cycle latency.
// Valid/ready pipeline holding up to 3 beats; a stalled output keeps q and out_valid stable.
module posit_encoder_pipe #(
  parameter int WIDTH = 8,
  parameter int ES    = 1,
  parameter int W_REG = $clog2(WIDTH) + 1,
  parameter int W_MAN = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic                    in_zero,
  input  logic                    in_nar,
  input  logic signed [W_REG-1:0] in_regime,
  input  logic        [ES-1:0]    in_exponent,
  input  logic        [W_MAN-1:0] in_mantissa,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] q
);

  // Longest regime run the signed input can express is 2^(W_REG-1) bits.
  localparam int RMAX = 1 << (W_REG - 1);
  localparam int V    = RMAX + 1 + ES + W_MAN;

  logic en1, en2, en3;

  logic             s1_vld, s1_sign, s1_zero, s1_nar, s1_guard, s1_sticky;
  logic [WIDTH-2:0] s1_body;
  logic             s2_vld, s2_sign, s2_zero, s2_nar;
  logic [WIDTH-2:0] s2_body;

  assign en3       = !out_valid || out_ready;
  assign en2       = !s2_vld || en3;
  assign en1       = !s1_vld || en2;
  assign in_ready  = en1;

  logic signed [W_REG:0] k_ext;
  logic        [W_REG:0] run_len;
  logic        [W_REG:0] shamt;
  logic        [V-1:0]   ideal;
  logic        [V-1:0]   aligned;

  // Build the widest possible regime run, then shift off the excess so exactly run_len bits remain.
  always_comb begin
    k_ext = {in_regime[W_REG-1], in_regime};
    if (in_regime[W_REG-1]) begin
      run_len = -k_ext;
      ideal   = {{RMAX{1'b0}}, 1'b1, in_exponent, in_mantissa};
    end else begin
      run_len = k_ext + (W_REG+1)'(1);
      ideal   = {{RMAX{1'b1}}, 1'b0, in_exponent, in_mantissa};
    end
    shamt   = (W_REG+1)'(RMAX) - run_len;
    aligned = ideal << shamt;
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-2:0] rounded;
  logic             round_up;

  // Clamping keeps nonzero values off the zero pattern and away from NaR.
  always_comb begin
    round_up = s1_guard && (s1_sticky || s1_body[0]);
    sum      = {1'b0, s1_body} + WIDTH'(round_up);
    if (sum[WIDTH-1]) begin
      rounded = '1;
    end else if (sum == '0) begin
      rounded = (WIDTH-1)'(1);
    end else begin
      rounded = sum[WIDTH-2:0];
    end
  end

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    mag = {1'b0, s2_body};
    if (s2_nar) begin
      q_next = {1'b1, {(WIDTH-1){1'b0}}};
    end else if (s2_zero) begin
      q_next = '0;
    end else if (s2_sign) begin
      q_next = -mag;
    end else begin
      q_next = mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_body   <= '0;
      s2_vld    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_nar    <= 1'b0;
      s2_body   <= '0;
      out_valid <= 1'b0;
      q         <= '0;
    end else begin
      if (en1) begin
        s1_vld <= in_valid;
        if (in_valid) begin
          s1_sign   <= in_sign;
          s1_zero   <= in_zero;
          s1_nar    <= in_nar;
          s1_body   <= aligned[V-1 -: WIDTH-1];
          s1_guard  <= aligned[V-WIDTH];
          s1_sticky <= |aligned[V-WIDTH-1:0];
        end
      end
      if (en2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_sign <= s1_sign;
          s2_zero <= s1_zero;
          s2_nar  <= s1_nar;
          s2_body <= rounded;
        end
      end
      if (en3) begin
        out_valid <= s2_vld;
        if (s2_vld) begin
          q <= q_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Directed bench for posit_encoder_pipe (WIDTH=8, ES=1): encodes, rounding, saturation, specials,
// throughput, backpressure and asynchronous reset, against hand-computed posit values.
module tb_posit_encoder_pipe;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic              in_zero;
  logic              in_nar;
  logic signed [3:0] in_regime;
  logic        [0:0] in_exponent;
  logic        [7:0] in_mantissa;
  logic              out_valid;
  logic              out_ready;
  logic        [7:0] q;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       s;
    logic       z;
    logic       n;
    int         k;
    int         e;
    int         m;
    logic [7:0] exp;
  } vec_t;

  posit_encoder_pipe #(.WIDTH(8), .ES(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_zero     (in_zero),
    .in_nar      (in_nar),
    .in_regime   (in_regime),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q)
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    in_sign     = v.s;
    in_zero     = v.z;
    in_nar      = v.n;
    in_regime   = 4'(v.k);
    in_exponent = 1'(v.e);
    in_mantissa = 8'(v.m);
  endtask

  // Sends one beat into an empty pipe and reports the result and edges-to-valid (transfer edge = 1).
  task automatic send_one(input vec_t v, output logic [7:0] got, output int lat);
    @(negedge clk);
    drive(v);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got = q;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('{1'b0, 1'b0, 1'b0, 0, 0, 0, 8'h00});
    #12;
    vectors++;
    if (out_valid !== 1'b0 || q !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: out_valid=%b q=%h, required out_valid=0 q=00", out_valid, q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    vec_t       v[3];
    logic [7:0] got;
    int         lat;
    v[0] = '{1'b0, 1'b0, 1'b0,  0, 0, 'h00, 8'h40};
    v[1] = '{1'b1, 1'b0, 1'b0,  0, 0, 'h00, 8'hC0};
    v[2] = '{1'b0, 1'b0, 1'b0, -1, 1, 'h00, 8'h30};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i], got, lat);
      vectors++;
      if (got !== v[i].exp || lat !== 3) begin
        miscompares++;
        $display("FAIL basic[%0d]: q=%h latency=%0d, required q=%h latency=3", i, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_rounding;
    vec_t       v[3];
    logic [7:0] got;
    int         lat;
    v[0] = '{1'b0, 1'b0, 1'b0, 0, 0, 'h88, 8'h48};
    v[1] = '{1'b0, 1'b0, 1'b0, 0, 0, 'h98, 8'h4A};
    v[2] = '{1'b0, 1'b0, 1'b0, 0, 0, 'h8C, 8'h49};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i], got, lat);
      vectors++;
      if (got !== v[i].exp || lat !== 3) begin
        miscompares++;
        $display("FAIL rne[%0d]: q=%h latency=%0d, required q=%h latency=3", i, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_saturation;
    vec_t       v[8];
    logic [7:0] got;
    int         lat;
    v[0] = '{1'b0, 1'b0, 1'b0,  6, 1, 'hFF, 8'h7F};
    v[1] = '{1'b0, 1'b0, 1'b0,  7, 0, 'h00, 8'h7F};
    v[2] = '{1'b1, 1'b0, 1'b0,  7, 1, 'h55, 8'h81};
    v[3] = '{1'b0, 1'b0, 1'b0,  5, 1, 'hFF, 8'h7F};
    v[4] = '{1'b0, 1'b0, 1'b0, -8, 1, 'hFF, 8'h01};
    v[5] = '{1'b1, 1'b0, 1'b0, -8, 0, 'h00, 8'hFF};
    v[6] = '{1'b0, 1'b0, 1'b0, -7, 0, 'h00, 8'h01};
    v[7] = '{1'b0, 1'b0, 1'b0, -7, 1, 'h00, 8'h01};
    for (int i = 0; i < 8; i++) begin
      send_one(v[i], got, lat);
      vectors++;
      if (got !== v[i].exp || lat !== 3) begin
        miscompares++;
        $display("FAIL sat[%0d]: q=%h latency=%0d, required q=%h latency=3", i, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_specials;
    vec_t       v[3];
    logic [7:0] got;
    int         lat;
    v[0] = '{1'b0, 1'b1, 1'b1, 3, 1, 'hA5, 8'h80};
    v[1] = '{1'b1, 1'b0, 1'b1, 0, 0, 'h00, 8'h80};
    v[2] = '{1'b1, 1'b1, 1'b0, 2, 1, 'h3C, 8'h00};
    for (int i = 0; i < 3; i++) begin
      send_one(v[i], got, lat);
      vectors++;
      if (got !== v[i].exp || lat !== 3) begin
        miscompares++;
        $display("FAIL special[%0d]: q=%h latency=%0d, required q=%h latency=3", i, got, lat, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[4];
    v[0] = '{1'b0, 1'b0, 1'b0,  0, 0, 'h00, 8'h40};
    v[1] = '{1'b1, 1'b0, 1'b0,  0, 0, 'h00, 8'hC0};
    v[2] = '{1'b0, 1'b0, 1'b0, -1, 1, 'h00, 8'h30};
    v[3] = '{1'b0, 1'b0, 1'b0,  0, 0, 'h8C, 8'h49};
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        vectors++;
        if (c < 7 && (out_valid !== 1'b1 || q !== v[c-3].exp)) begin
          miscompares++;
          $display("FAIL b2b_out[%0d]: out_valid=%b q=%h, required out_valid=1 q=%h",
                   c - 3, out_valid, q, v[c-3].exp);
        end else if (c == 7 && out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
        end
      end
      if (c < 4) begin
        drive(v[c]);
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_in_ready[%0d]: in_ready=%b, required 1", c, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    vec_t v[5];
    int   acc = 0;
    v[0] = '{1'b0, 1'b0, 1'b0,  0, 0, 'h00, 8'h40};
    v[1] = '{1'b0, 1'b0, 1'b0, -1, 1, 'h00, 8'h30};
    v[2] = '{1'b0, 1'b0, 1'b0,  0, 0, 'h98, 8'h4A};
    v[3] = '{1'b1, 1'b0, 1'b0,  0, 0, 'h00, 8'hC0};
    v[4] = '{1'b0, 1'b0, 1'b0,  7, 1, 'hFF, 8'h7F};
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(v[acc]);
      in_valid = 1'b1;
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++;
    if (acc !== 3 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required accepted=3 in_ready=0", acc, in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || q !== v[0].exp) begin
        miscompares++;
        $display("FAIL bp_stable[%0d]: out_valid=%b q=%h, required out_valid=1 q=%h", c, out_valid, q, v[0].exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (c < 3 && (out_valid !== 1'b1 || q !== v[c].exp)) begin
        miscompares++;
        $display("FAIL bp_release[%0d]: out_valid=%b q=%h, required out_valid=1 q=%h", c, out_valid, q, v[c].exp);
      end else if (c == 3 && out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight;
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 0, 0, 'h00, 8'hC0};
    @(negedge clk);
    out_ready = 1'b0;
    drive(v);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || q !== 8'hC0) begin
      miscompares++;
      $display("FAIL rst_pre: out_valid=%b q=%h, required out_valid=1 q=c0", out_valid, q);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || q !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: out_valid=%b q=%h, required out_valid=0 q=00", out_valid, q);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_in_ready: in_ready=%b, required 1", in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_stale[%0d]: out_valid=%b q=%h, required out_valid=0", c, out_valid, q);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_specials;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/posit_encoder_pipe.md
Name: posit_encoder_pipe

Overview:
- Pipelined, parametrised posit encoder. Converts an internal-representation value (sign, regime, exponent, fraction, zero and NaR flags) into a WIDTH-bit posit with configurable exponent size ES.
- Applies round-to-nearest-even and saturates to maxpos/minpos.
- Sits at the output of the posit arithmetic datapath, behind the decoder/ALU stages.
- Uses a valid/ready handshake so the datapath can stall it.

Parameters:
- WIDTH, 8, posit width in bits (>= 4).
- ES, 1, posit exponent field size in bits (>= 1).
- W_REG, $clog2(WIDTH)+1, width of the signed regime input.
- W_MAN, WIDTH, input fraction width, excluding the hidden bit.

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input this cycle.
- in_sign  in  1  1 = negative value.
- in_zero  in  1  value is exactly zero.
- in_nar  in  1  value is NaR.
- in_regime  in  W_REG  signed regime k.
- in_exponent  in  ES  unsigned exponent e.
- in_mantissa  in  W_MAN  fraction bits, MSB-aligned, hidden 1 implicit.
- out_valid  out  1  q holds a valid encoded posit.
- out_ready  in  1  downstream accepts q this cycle.
- q  out  WIDTH  encoded posit.

Behaviour:
- Clock and reset:
  - One clock, clk. rst_n is asynchronous and active-low.
  - Reset clears all stage valid bits. out_valid=0, q=0.
  - in_ready=1 once rst_n is high.
  - Reset mid-operation discards every in-flight transaction.
- Transfers: an input transfers when in_valid&&in_ready. An output transfers when out_valid&&out_ready.
- Pipeline: three registered stages (S1 align, S2 round, S3 sign/special). Latency is 3 cycles from input transfer to out_valid, with no bubbles when out_ready=1.
- Stage advance:
  - Stage n advances when its successor is empty or advancing.
  - in_ready = !S1_valid || S1_advancing.
  - Throughput is 1 transaction per cycle.
- Stall behaviour:
  - While out_valid && !out_ready, q and out_valid stay stable.
  - At most 3 transactions are held, after which in_ready deasserts.
  - Order is preserved. No transaction is dropped or duplicated.
- S1, alignment:
  - Regime field for k >= 0: k+1 ones, then a 0.
  - Regime field for k < 0: -k zeros, then a 1.
  - Ideal body string = regime field, ES exponent bits (MSB first), then the W_MAN fraction bits.
  - Keep the top WIDTH-1 bits as the body.
  - Guard = next bit. Sticky = OR of all remaining bits.
  - Run lengths >= WIDTH-1 truncate naturally. The guard and sticky of the truncated string still apply.
- S2, rounding:
  - Round up when guard && (sticky || body LSB).
  - The body result is clamped to [1, 2^(WIDTH-1)-1].
  - Effect: a nonzero value never rounds to 0 and never overflows into the NaR pattern.
  - A positive input with k >= WIDTH-2 yields maxpos 0111..1.
  - k <= -(WIDTH-1) yields minpos 000..01.
- S3, sign and specials:
  - in_sign=1 gives q = two's complement of {0, body}.
  - in_nar has priority over in_zero and gives q = 1000..0.
  - in_zero (with in_nar=0) gives q = 0.
  - The regime, exponent and mantissa inputs are ignored for NaR and zero.
- Data qualification: data inputs are sampled only on an input transfer. Outside a transfer they are don't-care.

Test Plan (WIDTH=8, ES=1, W_MAN=8):
- Basic encodes:
  - k=0, e=0, mant=0x00, sign=0 -> q=0x40 three cycles later.
  - The same with sign=1 -> q=0xC0.
  - k=-1, e=1, mant=0 -> q=0x30.
- Round-to-nearest-even, k=0, e=0:
  - mant=0x88 (tie, LSB 0) -> q=0x48.
  - mant=0x98 (tie, LSB 1) -> q=0x4A.
  - mant=0x8C (guard and sticky set) -> q=0x49.
- Saturation:
  - k=6 or k=7, any e/mant -> q=0x7F.
  - k=-8, sign=0 -> q=0x01.
  - k=-8, sign=1 -> q=0xFF.
- Specials:
  - in_nar=1 together with in_zero=1 -> q=0x80.
  - in_zero=1 alone -> q=0x00.
- Backpressure:
  - Setup: out_ready=0, five back-to-back in_valid beats.
  - Three are accepted, then in_ready=0, and q stays stable while stalled.
  - Release with out_ready=1: results appear in order on consecutive cycles.
- Reset:
  - Assert rst_n=0 with 3 in flight -> out_valid=0 and q=0 immediately, asynchronously.
  - After release, in_ready=1 and no stale outputs appear.
